ram_access_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 4096x4 single-port RAM (cs, we, 12-bit dir,
//  4-bit bidirectional data) between two requesters A and B. Latches the winner's request,

---
 rtl/ram_access_arbiter.sv | 104 ++++++++++
 tb/tb_ram_access_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B.
// Latches the winning request, runs the RAM access and returns a one-cycle ack.
module ram_access_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 4,
  parameter int ACCESS_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_dir,
  inout  wire  [DATA_W-1:0] ram_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam int CW = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYC - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              last_b;
  logic              cur_b;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_a;
  logic              grant_b;

  // On a tie the side that did not win last time gets the grant
  always_comb begin
    grant_a = a_req && (!b_req || last_b);
    grant_b = b_req && !grant_a;
  end

  assign ram_data = (ram_cs && ram_we) ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      last_b  <= 1'b1;
      cur_b   <= 1'b0;
      wdata_q <= '0;
      ram_cs  <= 1'b0;
      ram_we  <= 1'b0;
      ram_dir <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant_a || grant_b) begin
            state   <= S_ACCESS;
            cnt     <= '0;
            cur_b   <= grant_b;
            last_b  <= grant_b;
            ram_cs  <= 1'b1;
            ram_we  <= grant_b ? b_we : a_we;
            ram_dir <= grant_b ? b_addr : a_addr;
            wdata_q <= grant_b ? b_wdata : a_wdata;
          end
        end
        S_ACCESS: begin
          if (cnt == LAST) begin
            state  <= S_ACK;
            ram_cs <= 1'b0;
            ram_we <= 1'b0;
            a_ack  <= !cur_b;
            b_ack  <= cur_b;
            if (!ram_we) begin
              if (cur_b) b_rdata <= ram_data;
              else       a_rdata <= ram_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK: begin
          state <= S_IDLE;
          a_ack <= 1'b0;
          b_ack <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 4096x4 RAM.
// Covers reset, read/write, ties, round-robin, long access and mid-access reset.
module tb_ram_access_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_req0, a_we0, b_req0, b_we0;
  logic [11:0] a_addr0, b_addr0;
  logic [3:0]  a_wdata0, b_wdata0;
  logic        a_ack0, b_ack0;
  logic [3:0]  a_rdata0, b_rdata0;
  logic        cs0, we0;
  logic [11:0] dir0;
  tri1  [3:0]  data0;
  logic [3:0]  mem0 [4096];

  logic        a_req3, a_we3, b_req3, b_we3;
  logic [11:0] a_addr3, b_addr3;
  logic [3:0]  a_wdata3, b_wdata3;
  logic        a_ack3, b_ack3;
  logic [3:0]  a_rdata3, b_rdata3;
  logic        cs3, we3;
  logic [11:0] dir3;
  tri1  [3:0]  data3;
  logic [3:0]  mem3 [4096];

  ram_access_arbiter #(.ADDR_W(12), .DATA_W(4), .ACCESS_CYC(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req0), .a_we(a_we0), .a_addr(a_addr0), .a_wdata(a_wdata0),
    .a_ack(a_ack0), .a_rdata(a_rdata0),
    .b_req(b_req0), .b_we(b_we0), .b_addr(b_addr0), .b_wdata(b_wdata0),
    .b_ack(b_ack0), .b_rdata(b_rdata0),
    .ram_cs(cs0), .ram_we(we0), .ram_dir(dir0), .ram_data(data0)
  );

  ram_access_arbiter #(.ADDR_W(12), .DATA_W(4), .ACCESS_CYC(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req3), .a_we(a_we3), .a_addr(a_addr3), .a_wdata(a_wdata3),
    .a_ack(a_ack3), .a_rdata(a_rdata3),
    .b_req(b_req3), .b_we(b_we3), .b_addr(b_addr3), .b_wdata(b_wdata3),
    .b_ack(b_ack3), .b_rdata(b_rdata3),
    .ram_cs(cs3), .ram_we(we3), .ram_dir(dir3), .ram_data(data3)
  );

  // RAM models: drive the bus only on reads; idle bus floats high
  assign data0 = (cs0 && !we0) ? mem0[dir0] : 4'bzzzz;
  assign data3 = (cs3 && !we3) ? mem3[dir3] : 4'bzzzz;
  always @(posedge clk) if (cs0 && we0) mem0[dir0] <= data0;
  always @(posedge clk) if (cs3 && we3) mem3[dir3] <= data3;

  always @(negedge clk) begin
    total++;
    if (cs0 && !we0 && data0 !== mem0[dir0]) begin
      bad++;
      $display("FAIL bus0_read data=%h want=%h", data0, mem0[dir0]);
    end else if (!cs0 && (data0 !== 4'hF || we0 !== 1'b0)) begin
      bad++;
      $display("FAIL bus0_idle data=%h we=%b want F/0", data0, we0);
    end
    total++;
    if (!cs3 && (data3 !== 4'hF || we3 !== 1'b0)) begin
      bad++;
      $display("FAIL bus3_idle data=%h we=%b want F/0", data3, we3);
    end
    total++;
    if (a_ack0 && b_ack0) begin
      bad++;
      $display("FAIL dual_ack a=%b b=%b want one", a_ack0, b_ack0);
    end
  end

  task automatic xact(input bit side, input bit we, input logic [11:0] addr,
                      input logic [3:0] wd, output logic [3:0] rd,
                      output int lat, output int csn);
    lat = 0;
    csn = 0;
    @(posedge clk); #1;
    if (!side) begin
      a_req0 = 1'b1; a_we0 = we; a_addr0 = addr; a_wdata0 = wd;
    end else begin
      b_req0 = 1'b1; b_we0 = we; b_addr0 = addr; b_wdata0 = wd;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cs0) csn++;
      if (side ? b_ack0 : a_ack0) break;
    end
    a_req0 = 1'b0;
    b_req0 = 1'b0;
    rd = side ? b_rdata0 : a_rdata0;
  endtask

  task automatic xact3(input bit we, input logic [11:0] addr,
                       input logic [3:0] wd, output logic [3:0] rd,
                       output int lat, output int csn);
    lat = 0;
    csn = 0;
    @(posedge clk); #1;
    a_req3 = 1'b1; a_we3 = we; a_addr3 = addr; a_wdata3 = wd;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cs3) csn++;
      if (a_ack3) break;
    end
    a_req3 = 1'b0;
    rd = a_rdata3;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if (cs0 !== 1'b0 || we0 !== 1'b0 || dir0 !== 12'h000) begin
      bad++;
      $display("FAIL reset_ram cs=%b we=%b dir=%h want 0", cs0, we0, dir0);
    end
    total++;
    if (a_ack0 !== 1'b0 || b_ack0 !== 1'b0 || a_rdata0 !== 4'h0 || b_rdata0 !== 4'h0) begin
      bad++;
      $display("FAIL reset_out ack=%b%b rd=%h/%h want 0", a_ack0, b_ack0, a_rdata0, b_rdata0);
    end
    total++;
    if (data0 !== 4'hF) begin
      bad++;
      $display("FAIL reset_bus data=%h want F", data0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read;
    logic [3:0] rd;
    int lat, csn;
    xact(1'b0, 1'b1, 12'h0A5, 4'hC, rd, lat, csn);
    total++;
    if (lat != 2 || csn != 1) begin
      bad++;
      $display("FAIL wr_timing lat=%0d cs=%0d want 2/1", lat, csn);
    end
    @(posedge clk); #1;
    total++;
    if (a_ack0 !== 1'b0) begin
      bad++;
      $display("FAIL ack_pulse ack=%b want 0", a_ack0);
    end
    xact(1'b0, 1'b0, 12'h0A5, 4'h0, rd, lat, csn);
    total++;
    if (lat != 2 || csn != 1 || rd !== 4'hC) begin
      bad++;
      $display("FAIL rd_0a5 lat=%0d cs=%0d rd=%h want 2/1/C", lat, csn, rd);
    end
  endtask

  task automatic test_tie;
    logic [3:0] rd;
    int lat, csn, ta, tb;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ta = -1;
    tb = -1;
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 12'h123; a_wdata0 = 4'h5;
    b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 12'hFFF; b_wdata0 = 4'h3;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (a_ack0) begin ta = i; a_req0 = 1'b0; end
      if (b_ack0) begin tb = i; b_req0 = 1'b0; end
      if (ta >= 0 && tb >= 0) break;
    end
    a_req0 = 1'b0;
    b_req0 = 1'b0;
    total++;
    if (ta != 2 || tb != 5) begin
      bad++;
      $display("FAIL tie_order a_ack@%0d b_ack@%0d want 2/5", ta, tb);
    end
    xact(1'b0, 1'b0, 12'hFFF, 4'h0, rd, lat, csn);
    total++;
    if (rd !== 4'h3) begin
      bad++;
      $display("FAIL rd_fff rd=%h want 3", rd);
    end
    xact(1'b0, 1'b0, 12'h123, 4'h0, rd, lat, csn);
    total++;
    if (rd !== 4'h5) begin
      bad++;
      $display("FAIL rd_123 rd=%h want 5", rd);
    end
  endtask

  task automatic test_alternate;
    int k;
    bit exp_b;
    logic [3:0] got, exp_d;
    k = 0;
    @(posedge clk); #1;
    a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 12'hFFF;
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 12'h0A5;
    for (int i = 0; i < 40 && k < 8; i++) begin
      @(posedge clk); #1;
      if (a_ack0 || b_ack0) begin
        // A was granted last, so B leads the alternation
        exp_b = (k % 2 == 0);
        total++;
        if (b_ack0 !== exp_b) begin
          bad++;
          $display("FAIL rr_seq%0d b_ack=%b want %b", k, b_ack0, exp_b);
        end
        got   = exp_b ? b_rdata0 : a_rdata0;
        exp_d = exp_b ? 4'hC : 4'h3;
        total++;
        if (got !== exp_d) begin
          bad++;
          $display("FAIL rr_data%0d rd=%h want %h", k, got, exp_d);
        end
        k++;
      end
    end
    a_req0 = 1'b0;
    b_req0 = 1'b0;
    total++;
    if (k != 8) begin
      bad++;
      $display("FAIL rr_count acks=%0d want 8", k);
    end
  endtask

  task automatic test_drop;
    logic [3:0] rd;
    int lat, csn, n;
    n = 0;
    @(posedge clk); #1;
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 12'h055; a_wdata0 = 4'h6;
    @(posedge clk); #1;
    total++;
    if (cs0 !== 1'b1 || dir0 !== 12'h055) begin
      bad++;
      $display("FAIL drop_grant cs=%b dir=%h want 1/055", cs0, dir0);
    end
    a_req0 = 1'b0; a_we0 = 1'b0; a_addr0 = 12'h0AA; a_wdata0 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (a_ack0) n++;
    end
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL drop_ack pulses=%0d want 1", n);
    end
    xact(1'b0, 1'b0, 12'h055, 4'h0, rd, lat, csn);
    total++;
    if (rd !== 4'h6) begin
      bad++;
      $display("FAIL drop_data rd=%h want 6", rd);
    end
  endtask

  task automatic test_access3;
    logic [3:0] rd;
    int lat, csn;
    xact3(1'b1, 12'h000, 4'h9, rd, lat, csn);
    total++;
    if (lat != 4 || csn != 3) begin
      bad++;
      $display("FAIL acc3_wr lat=%0d cs=%0d want 4/3", lat, csn);
    end
    xact3(1'b0, 12'h000, 4'h0, rd, lat, csn);
    total++;
    if (lat != 4 || csn != 3 || rd !== 4'h9) begin
      bad++;
      $display("FAIL acc3_rd lat=%0d cs=%0d rd=%h want 4/3/9", lat, csn, rd);
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0] rd;
    int lat, csn, n;
    n = 0;
    @(posedge clk); #1;
    a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 12'h0A5; a_wdata0 = 4'h7;
    a_req3 = 1'b1; a_we3 = 1'b1; a_addr3 = 12'h000; a_wdata3 = 4'h1;
    @(posedge clk); #1;
    total++;
    if (cs0 !== 1'b1 || cs3 !== 1'b1) begin
      bad++;
      $display("FAIL mid_start cs0=%b cs3=%b want 1/1", cs0, cs3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (cs0 !== 1'b0 || we0 !== 1'b0 || dir0 !== 12'h000 || data0 !== 4'hF) begin
      bad++;
      $display("FAIL mid_ram cs=%b we=%b dir=%h data=%h want 0/0/000/F", cs0, we0, dir0, data0);
    end
    total++;
    if (a_rdata0 !== 4'h0 || a_rdata3 !== 4'h0 || cs3 !== 1'b0 || data3 !== 4'hF) begin
      bad++;
      $display("FAIL mid_clear rd0=%h rd3=%h cs3=%b data3=%h want 0/0/0/F",
               a_rdata0, a_rdata3, cs3, data3);
    end
    a_req0 = 1'b0;
    a_req3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (a_ack0 || b_ack0 || a_ack3 || b_ack3) n++;
    end
    total++;
    if (n != 0) begin
      bad++;
      $display("FAIL mid_noack acks=%0d want 0", n);
    end
    rst_n = 1'b1;
    xact(1'b0, 1'b0, 12'h0A5, 4'h0, rd, lat, csn);
    total++;
    if (lat != 2 || rd !== 4'hC) begin
      bad++;
      $display("FAIL mid_restart lat=%0d rd=%h want 2/C", lat, rd);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req0 = 0; a_we0 = 0; a_addr0 = '0; a_wdata0 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    a_req3 = 0; a_we3 = 0; a_addr3 = '0; a_wdata3 = '0;
    b_req3 = 0; b_we3 = 0; b_addr3 = '0; b_wdata3 = '0;
    test_reset;
    test_write_read;
    test_tie;
    test_alternate;
    test_drop;
    test_access3;
    test_mid_reset;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
